// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and legal WIDTH limits for the
// bit-serial adder.
package serial_adder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sa_state_t;

    localparam int SA_WIDTH_MIN = 2;
    localparam int SA_WIDTH_MAX = 64;

endpackage

// File: rtl/fa_cell.sv
// fa_cell: purely combinational one-bit full adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (b & c) | (c & a);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder. Operands are captured on start,
// added LSB-first through a single fa_cell with a carry flop, and the result
// is presented with a one-cycle done pulse after WIDTH cycles.
// Optional feature: define SERIAL_ADDER_CIN_EN to add the cin port; without
// it the carry flop is loaded with 0 and the block computes a plain a+b.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CIN_EN
    input  logic             cin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    if (WIDTH < SA_WIDTH_MIN || WIDTH > SA_WIDTH_MAX) begin : g_width_check
        $error("serial_adder: WIDTH out of range");
    end

    sa_state_t        r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    // Only the WIDTH-1 upper partial-sum bits are stored; the newest bit
    // comes straight from the full adder in the completing cycle.
    logic [WIDTH-2:0] r_s_sr;
    logic             r_c_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic             w_s;
    logic             w_co;
    logic             w_cin;
    logic [WIDTH-1:0] w_s_next;

`ifdef SERIAL_ADDER_CIN_EN
    assign w_cin = cin;
`else
    assign w_cin = 1'b0;
`endif

    fa_cell u_fa (
        .a     (r_a_sr[0]),
        .b     (r_b_sr[0]),
        .c     (r_c_q),
        .sum   (w_s),
        .carry (w_co)
    );

    assign w_s_next = {w_s, r_s_sr};

    // FSM, operand/sum shift registers, carry flop, counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_c_q   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_c_q   <= w_cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_s_sr <= w_s_next[WIDTH-1:1];
                    r_c_q  <= w_co;
                    if (r_cnt == LAST_CNT) begin
                        // Counter parks at its last value so it never wraps.
                        r_sum   <= w_s_next;
                        r_carry <= w_co;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven and scoreboard-checked bench for serial_adder
// at WIDTH=8, with hand-written sequences for ignored start, mid-operation
// reset and back-to-back operation.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;

    int errors = 0;
    int checks = 0;

    logic [W:0] sb[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_carry;
    } vec_t;

    vec_t vecs[7];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_CIN_EN
        .cin   (cin),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference: {carry,sum} = a + b + cin (cin only in the cin-enabled build).
    function automatic logic [W:0] model(logic [W-1:0] ia, logic [W-1:0] ib, logic ic);
        logic [W:0] r;
`ifdef SERIAL_ADDER_CIN_EN
        r = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
`else
        r = {1'b0, ia} + {1'b0, ib};
`endif
        return r;
    endfunction

    // Drive a start so it is sampled at the next rising edge (E0); returns at E0+1.
    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic ic, input logic [W:0] exp, input bit at_neg);
        if (at_neg) @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        sb.push_back(exp);
    endtask

    // Wait (bounded) for done; report edges taken, busy samples and sum stability.
    task automatic wait_done(output int lat, output int bcnt, output bit held);
        logic [W-1:0] prev;
        prev = sum; lat = 0; bcnt = 0; held = 1'b1;
        while (lat < 20) begin
            if (busy) bcnt++;
            @(posedge clk); #1; lat++;
            if (done) return;
            if (sum !== prev) held = 1'b0;
        end
    endtask

    task automatic check_result(string tag);
        logic [W:0] exp;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_sb: got done with no expected entry, expected an entry", tag);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
            chk({tag, "_carry"}, 64'(carry), 64'(exp[W]));
        end
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    // Count done pulses over n cycles with no start.
    task automatic no_done(string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int lat, bcnt;
        bit held;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
`ifdef SERIAL_ADDER_CIN_EN
        vecs[6] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
`else
        vecs[6] = '{8'hFF, 8'h00, 1'b1, 8'hFF, 1'b0};
`endif

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_carry", 64'(carry), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin,
                     {vecs[i].exp_carry, vecs[i].exp_sum}, 1'b1);
            wait_done(lat, bcnt, held);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd8);
            chk($sformatf("vec%0d_sum_held", i), 64'(held), 64'd1);
            check_result($sformatf("vec%0d", i));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_one_cycle", i), 64'(done), 64'd0);
        end

        // Start pulsed at E3 during 0x10+0x20 must be ignored.
        start_op(8'h10, 8'h20, 1'b0, model(8'h10, 8'h20, 1'b0), 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bcnt, held);
        chk("ign_latency_after_E3", 64'(lat), 64'd5);
        check_result("ign");
        no_done("ign_no_extra_done", 12);

        // Reset asserted between E3 and E4 of 0xFF+0xFF aborts the operation.
        start_op(8'hFF, 8'hFF, 1'b0, model(8'hFF, 8'hFF, 1'b0), 1'b1);
        void'(sb.pop_back());
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_carry", 64'(carry), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        no_done("abort_no_done", 12);
        start_op(8'h03, 8'h04, 1'b0, model(8'h03, 8'h04, 1'b0), 1'b1);
        wait_done(lat, bcnt, held);
        chk("post_rst_latency", 64'(lat), 64'd8);
        check_result("post_rst");

        // Back-to-back: start issued in the done cycle of 0x01+0x02.
        @(posedge clk); #1;
        start_op(8'h01, 8'h02, 1'b0, model(8'h01, 8'h02, 1'b0), 1'b1);
        wait_done(lat, bcnt, held);
        chk("b2b_first_latency", 64'(lat), 64'd8);
        check_result("b2b_first");
        start_op(8'h10, 8'h10, 1'b0, model(8'h10, 8'h10, 1'b0), 1'b0);
        chk("b2b_busy_after_accept", 64'(busy), 64'd1);
        chk("b2b_first_sum_held_early", 64'(sum), 64'h03);
        wait_done(lat, bcnt, held);
        chk("b2b_second_latency", 64'(lat + 1), 64'd9);
        chk("b2b_first_sum_held", 64'(held), 64'd1);
        check_result("b2b_second");

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around a single one-bit full-adder cell and a carry flip-flop. It accepts two WIDTH-bit operands on a start pulse and adds them LSB-first, one bit per clock. It returns the WIDTH-bit sum and carry-out with a one-cycle done pulse. It is the sequential stage directly above the gate-level full adder and trades latency for area in the arithmetic datapath.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..64.
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start. Present only with SERIAL_ADDER_CIN_EN.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when sum and carry become valid.
- sum  output  WIDTH  result, registered, held until the next completion.
- carry  output  1  carry-out of bit WIDTH-1, registered, held with sum.

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT: adding one bit per cycle.
- IDLE with start=1:
  - Load a_sr<=a, b_sr<=b, c_q<=cin (or 0), cnt<=0, busy<=1.
  - Go to SHIFT.
- IDLE with start=0: hold all registers.
- Each SHIFT cycle:
  - The full-adder cell computes s and co from a_sr[0], b_sr[0] and c_q.
  - s_sr<={s, s_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by one bit, zero-filled.
  - c_q<=co; cnt<=cnt+1.
- Completion, in the SHIFT cycle with cnt==WIDTH-1:
  - sum<={s, s_sr[WIDTH-1:1]}, carry<=co.
  - done<=1, busy<=0.
  - Return to IDLE.
- Arithmetic: {carry,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1). Overflow out of WIDTH bits appears only on carry.
- start while busy=1 is ignored. It is not queued and does not affect the operation in flight. a, b and cin may change freely after capture.
- Reset asserted, at any time including mid-operation:
  - State goes to IDLE immediately; the current operation is discarded.
  - busy, done, sum, carry and all internal registers go to 0.
  - No done is issued for the aborted operation.
- The cnt register is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.

## Timing
- Edge E0 samples start=1.
- Edges E1..E(WIDTH) perform the bit additions.
- At edge E(WIDTH), done=1 and sum/carry are valid. Latency from start acceptance to done is WIDTH cycles.
- busy is high from after E0 until E(WIDTH), i.e. exactly WIDTH cycles.
- done is high for exactly one cycle.
- The block is in IDLE during the done cycle. A start in that cycle is accepted, giving back-to-back throughput of one result per WIDTH+1 cycles.
- sum and carry change only at completion edges and at reset.
- Reset values: busy=0, done=0, sum=0, carry=0.

## Configuration
- SERIAL_ADDER_CIN_EN defined:
  - The cin port exists.
  - cin is captured into c_q on accepted start.
- SERIAL_ADDER_CIN_EN undefined:
  - There is no cin port.
  - c_q loads 0 on start, giving a plain a+b.
- All other behaviour and timing are identical in both builds.

## Structure
- Shared package serial_adder_pkg:
  - State enum (IDLE, SHIFT).
  - WIDTH limits as constants: SA_WIDTH_MIN=2, SA_WIDTH_MAX=64.
- Sub-module: one instance of fa_cell, a purely combinational one-bit full adder.
  - Ports a, b, c, sum, carry.
  - sum = a^b^c; carry = ab|bc|ca.
- The top holds the FSM, counter, shift registers, carry flop and output registers.

## Test plan
All scenarios use WIDTH=8.
- 0x00+0x00, start at E0 -> done one cycle at E8, sum=0x00, carry=0, busy high exactly 8 cycles.
- 0xFF+0x01 -> sum=0x00, carry=1; 0xA5+0x5A -> sum=0xFF, carry=0; 0x80+0x80 -> sum=0x00, carry=1.
- start pulsed again at E3 with a=0x01, b=0x01 during 0x10+0x20 -> ignored; result sum=0x30, carry=0 at E8.
- rst_n low at E4 of 0xFF+0xFF -> busy, done, sum and carry are 0 immediately; no done follows. A new start after release of 0x03+0x04 -> sum=0x07.
- start asserted in the done cycle of 0x01+0x02 (sum=0x03) with 0x10+0x10 -> second done 9 cycles after the first, sum=0x20. The first sum stays held until then.
- With SERIAL_ADDER_CIN_EN, 0xFF+0x00 with cin=1 -> sum=0x00, carry=1. Without the macro, the same operands -> sum=0xFF, carry=0.
